// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value
    function automatic logic writes_reg(input logic       we,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX-stage forwarding select for one source operand
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    // The younger result in M shadows the older one in W
    always_comb begin
        fwd_sel = FWD_REG;
        if (writes_reg(reg_write_m, rd_m, rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (writes_reg(reg_write_w, rd_w, rs_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, load-use, redirect and memory-wait sequencing; HAZARD_PERF_EN adds perf counters
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT) + 1,
    parameter int unsigned PERF_W      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RS1D,
    input  logic [4:0] RS2D,
    input  logic [4:0] RS1E,
    input  logic [4:0] RS2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic [1:0] ResultSrcE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_loaduse,
    output logic [PERF_W-1:0] perf_redirects
`endif
);

    hz_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_err_q, mem_err_d;

    logic [1:0]        fwd_a, fwd_b;
    logic              lw_stall;
    logic              freeze;

    hazard_fwd_unit u_fwd_a (
        .rs_e        (RS1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .rs_e        (RS2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    // Freeze is decoded from the transition condition so it bites in the
    // miss cycle itself and releases in the ready cycle
    always_comb begin
        lw_stall = (ResultSrcE == RESULTSRC_LOAD) && (RdE != 5'd0) &&
                   ((RdE == RS1D) || (RdE == RS2D));
        freeze   = 1'b1;
        case (state_q)
            RUN:      freeze = dmem_req_M && !dmem_ready;
            MEM_WAIT: freeze = !dmem_ready;
            default:  freeze = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (dmem_req_M && !dmem_ready) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // A redirect seen while frozen is simply held in E by StallE and
    // acted on once the freeze drops
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;
        if (reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
            end
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
    logic [PERF_W-1:0] perf_rd_q, perf_rd_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_lu_d    = perf_lu_q;
        perf_rd_d    = perf_rd_q;
        if (freeze && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
        if (!freeze && lw_stall && (perf_lu_q != '1)) begin
            perf_lu_d = perf_lu_q + PERF_W'(1);
        end
        if (!freeze && PCSrcE && (perf_rd_q != '1)) begin
            perf_rd_d = perf_rd_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_lu_q    <= '0;
            perf_rd_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_lu_q    <= perf_lu_d;
            perf_rd_q    <= perf_rd_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_loaduse      = perf_lu_q;
    assign perf_redirects    = perf_rd_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int unsigned TO = 8;

    logic       clk;
    logic       reset;
    logic [4:0] RS1D, RS2D, RS1E, RS2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, dmem_req_M, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_loaduse, perf_redirects;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .RS1D       (RS1D),
        .RS2D       (RS2D),
        .RS1E       (RS1E),
        .RS2E       (RS2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .ResultSrcE (ResultSrcE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .mem_err    (mem_err)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_loaduse      (perf_loaduse),
        .perf_redirects    (perf_redirects)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, mem_err}
    logic [11:0] act;
    assign act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE, mem_err};

    function automatic logic [11:0] pk(input logic [3:0] st, input logic [2:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err);
        return {st, fl, fa, fb, err};
    endfunction

    function automatic logic [11:0] frozen(input logic err);
        return pk(4'b1111, 3'b001, 2'b00, 2'b00, err);
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RS1D = 5'd0; RS2D = 5'd0; RS1E = 5'd0; RS2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] res;
        logic       rwm, rww, pc, req, rdy;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n,
                           input logic [4:0] rs1d, input logic [4:0] rs2d,
                           input logic [4:0] rs1e, input logic [4:0] rs2e,
                           input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                           input logic [1:0] res, input logic rwm, input logic rww,
                           input logic pc, input logic req, input logic rdy,
                           input logic [11:0] exp);
        vec_t v;
        v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.res = res; v.rwm = rwm; v.rww = rww;
        v.pc = pc; v.req = req; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Reference model: an outstanding access ages one step per unanswered
    // cycle in the wait; TO unanswered wait cycles trap for good
    bit m_busy, m_halt, m_err;
    int m_waited;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] ref_out();
        logic lw, frz;
        lw  = (ResultSrcE == 2'b01) && RdE != 5'd0 && (RdE == RS1D || RdE == RS2D);
        frz = m_halt || (m_busy ? !dmem_ready : (dmem_req_M && !dmem_ready));
        if (frz) return pk(4'b1111, 3'b001, ref_fwd(RS1E), ref_fwd(RS2E), m_err);
        return pk({lw, lw, 2'b00}, {PCSrcE, lw | PCSrcE, 1'b0},
                  ref_fwd(RS1E), ref_fwd(RS2E), m_err);
    endfunction

    task automatic ref_step();
        if (!m_halt) begin
            if (m_busy) begin
                if (dmem_ready) begin
                    m_busy = 1'b0;
                end else begin
                    m_waited++;
                    if (m_waited == int'(TO)) begin
                        m_halt = 1'b1;
                        m_err  = 1'b1;
                    end
                end
            end else if (dmem_req_M && !dmem_ready) begin
                m_busy   = 1'b1;
                m_waited = 0;
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;

        // Reset holds every output low even with hazards on the inputs
        ResultSrcE = 2'b01; RdE = 5'd3; RS1D = 5'd3; PCSrcE = 1'b1;
        RegWriteM = 1'b1; RdM = 5'd4; RS1E = 5'd4; dmem_req_M = 1'b1;
        #2;
        check("reset_outputs", 12'd0);
        @(negedge clk);
        check("reset_outputs_clocked", 12'd0);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("reset_state_run", 12'd0);

        add_vec("fwd_m_priority", 0,0,5,0, 0,5,5, 2'b00, 1,1,0,0,0, pk(4'b0,3'b0,2'b10,2'b00,1'b0));
        add_vec("fwd_m_rd0",      0,0,5,0, 0,0,5, 2'b00, 1,1,0,0,0, pk(4'b0,3'b0,2'b01,2'b00,1'b0));
        add_vec("fwd_m_nowrite",  0,0,5,0, 0,5,5, 2'b00, 0,1,0,0,0, pk(4'b0,3'b0,2'b01,2'b00,1'b0));
        add_vec("fwd_split",      0,0,1,7, 0,7,1, 2'b00, 1,1,0,0,0, pk(4'b0,3'b0,2'b01,2'b10,1'b0));
        add_vec("fwd_x0",         0,0,0,0, 0,0,0, 2'b00, 1,1,0,0,0, pk(4'b0,3'b0,2'b00,2'b00,1'b0));
        add_vec("loaduse_rs2",    1,3,0,0, 3,0,0, 2'b01, 0,0,0,0,0, pk(4'b1100,3'b010,2'b00,2'b00,1'b0));
        add_vec("loaduse_rd0",    0,0,0,0, 0,0,0, 2'b01, 0,0,0,0,0, pk(4'b0,3'b0,2'b00,2'b00,1'b0));
        add_vec("nonload_alu",    3,0,0,0, 3,0,0, 2'b00, 0,0,0,0,0, pk(4'b0,3'b0,2'b00,2'b00,1'b0));
        add_vec("nonload_pc4",    3,0,0,0, 3,0,0, 2'b10, 0,0,0,0,0, pk(4'b0,3'b0,2'b00,2'b00,1'b0));
        add_vec("branch_taken",   0,0,0,0, 0,0,0, 2'b00, 0,0,1,0,0, pk(4'b0,3'b110,2'b00,2'b00,1'b0));
        add_vec("loaduse_branch", 3,0,0,0, 3,0,0, 2'b01, 0,0,1,0,0, pk(4'b1100,3'b110,2'b00,2'b00,1'b0));
        add_vec("mem_hit",        0,0,0,0, 0,0,0, 2'b00, 0,0,0,1,1, pk(4'b0,3'b0,2'b00,2'b00,1'b0));

        foreach (vecs[i]) begin
            cyc();
            RS1D = vecs[i].rs1d; RS2D = vecs[i].rs2d; RS1E = vecs[i].rs1e; RS2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; ResultSrcE = vecs[i].res;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pc;
            dmem_req_M = vecs[i].req; dmem_ready = vecs[i].rdy;
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp);
        end

        // Four-cycle memory wait with a redirect held in E
        cyc();
        clear_inputs();
        dmem_req_M = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wait_freeze%0d", i), frozen(1'b0));
            cyc();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        check("wait_release_redirect", pk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
        cyc();
        clear_inputs();
        @(negedge clk);
        check("wait_back_run", 12'd0);

        // Ready arriving on the last allowed wait cycle still wins
        cyc();
        dmem_req_M = 1'b1;
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check($sformatf("limit_freeze%0d", i), frozen(1'b0));
            cyc();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        check("ready_at_limit", 12'd0);
        cyc();
        clear_inputs();
        @(negedge clk);
        check("limit_back_run", 12'd0);

        // Timeout: one miss cycle in RUN plus TO wait cycles, then HALT
        cyc();
        dmem_req_M = 1'b1;
        for (int i = 0; i <= int'(TO); i++) begin
            @(negedge clk);
            check($sformatf("timeout_wait%0d", i), frozen(1'b0));
            cyc();
        end
        @(negedge clk);
        check("halt_entered", frozen(1'b1));
        cyc();
        dmem_req_M = 1'b0; dmem_ready = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("halt_sticky%0d", i), frozen(1'b1));
            cyc();
        end
        #2;
        reset = 1'b0;
        #1;
        check("halt_async_reset", 12'd0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_halt_reset", 12'd0);

        // Asynchronous reset between clock edges in the middle of a wait
        cyc();
        dmem_req_M = 1'b1;
        @(negedge clk);
        check("midwait_freeze0", frozen(1'b0));
        cyc();
        @(negedge clk);
        check("midwait_freeze1", frozen(1'b0));
        #2;
        reset = 1'b0;
        #1;
        check("midwait_async_reset", 12'd0);
        dmem_req_M = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midwait_post_reset_run", 12'd0);

        // Randomized traffic against the reference model
        m_busy = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_waited = 0;
        cyc();
        for (int n = 0; n < 600; n++) begin
            RS1D = 5'($urandom_range(0, 3)); RS2D = 5'($urandom_range(0, 3));
            RS1E = 5'($urandom_range(0, 3)); RS2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            dmem_req_M = ($urandom_range(0, 2) == 0);
            dmem_ready = m_busy ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("rand%0d", n), ref_out());
            @(posedge clk);
            ref_step();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and stall sequencer for the 5-stage RV32I pipeline.
- Computes the EX-stage forwarding selects.
- Detects load-use hazards and generates D/E flushes on taken branch, jal and jalr.
- Freezes the whole pipeline through an FSM while a variable-latency data memory access in MEM is outstanding, with a timeout trap.
- Drives the Stall/Flush inputs of the F, D, DE, EM and MW pipeline registers.

Parameters:
- MEM_TIMEOUT, 256, max cycles in MEM_WAIT before trapping; must be ≥2.
- CNT_W, $clog2(MEM_TIMEOUT)+1, wait-counter width.
- PERF_W, 32, width of the perf counters (HAZARD_PERF_EN only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RS1D, RS2D  in  5  source registers of the instruction in D.
- RS1E, RS2E  in  5  source registers of the instruction in E.
- RdE, RdM, RdW  in  5  destination registers in E, M and W.
- ResultSrcE  in  2  result select in E; 2'b01 = load.
- RegWriteM, RegWriteW  in  1  writeback enables in M and W.
- PCSrcE  in  1  taken branch, jal or jalr resolved in E.
- dmem_req_M  in  1  load/store active in M.
- dmem_ready  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC / FD / DE / EM registers.
- FlushD, FlushE, FlushW  out  1  bubble into the FD / DE / MW registers.
- ForwardAE, ForwardBE  out  2  00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM.
- mem_err  out  1  sticky timeout trap flag.

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN, wait counter 0, mem_err 0.
- While reset is low, every Stall/Flush output is 0 and ForwardAE/BE are 00.
- Forwarding (combinational, in every state), ForwardAE:
  - 10 if RegWriteM && RdM≠0 && RdM==RS1E;
  - else 01 if RegWriteW && RdW≠0 && RdW==RS1E;
  - else 00.
  - M has priority over W. ForwardBE is the same with RS2E.
- lwStall = (ResultSrcE==2'b01) && RdE≠0 && (RdE==RS1D || RdE==RS2D).
- RUN outputs:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = StallM = FlushW = 0.
- RUN transition: dmem_req_M && !dmem_ready → MEM_WAIT with counter cleared. The freeze takes effect in that same cycle, because the freeze outputs are decoded from the next-state condition (Mealy).
- MEM_WAIT / freeze outputs:
  - StallF = StallD = StallE = StallM = 1; FlushW = 1.
  - FlushD = FlushE = 0; lwStall and PCSrcE are suppressed.
  - A held PCSrcE flushes on the first RUN cycle after release. No redirect is lost.
- MEM_WAIT transitions:
  - dmem_ready → RUN. The freeze drops in the ready cycle, so the access retires exactly once.
  - No ready, counter == MEM_TIMEOUT-1 → HALT and set mem_err.
  - Otherwise counter increments.
- HALT: all four stalls = 1, FlushW = 1, flushes 0. Exits only on reset. mem_err stays 1.
- Simultaneous events:
  - dmem_ready in the same cycle the counter hits its limit: ready wins → RUN.
  - lwStall together with PCSrcE: FlushE = 1 and StallF/StallD = 1. The redirect from PCSrcE overrides the PC hold in the fetch mux.
- Reset mid-wait: immediate return to RUN, counter 0, mem_err 0.

Optional Feature:
- HAZARD_PERF_EN defined adds three outputs, perf_stall_cycles, perf_loaduse, perf_redirects (PERF_W each):
  - freeze/HALT cycles, lwStall cycles, PCSrcE flush cycles (RUN only).
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent and the core behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN, MEM_WAIT, HALT);
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - RESULTSRC_LOAD = 2'b01.
- One sub-module: hazard_fwd_unit, the purely combinational forwarding compare for one operand, instantiated twice.

Test Plan:
- Forwarding priority: RegWriteM=RegWriteW=1, RdM=RdW=RS1E=5 → ForwardAE=10. Same with RdM=0 → 01.
- Load-use: ResultSrcE=01, RdE=3, RS2D=3 → StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 → no stall.
- Branch: PCSrcE=1 in RUN → FlushD=FlushE=1, no stalls.
- Memory wait: dmem_req_M=1 with ready low for 4 cycles → 4 frozen cycles with FlushW=1. Ready cycle → RUN. A PCSrcE held across the wait flushes on the first RUN cycle.
- Timeout: MEM_TIMEOUT=8, ready never asserted → HALT after 8 MEM_WAIT cycles, mem_err=1 and stays. Reset low → RUN, mem_err=0.
- Async reset asserted mid-MEM_WAIT, no clock edge → outputs 0 immediately; after release state is RUN.
